deal_controller: RTL and testbench

- Sequences puzzle dealing for the 24 game; sits between the pseudo-random index generator, the valid-set ROM and the game FSM.
- On a new-game request it samples the random index and rejects indices used in the last HIST_DEPTH deals.
- It drives the ROM index, waits for the lookup, latches the four puzzle numbers and pulses a handshake to the FSM.
- A restart request re-presents the current puzzle without re-dealing.

---
 rtl/deal_controller.sv | 174 +++++++++++++++++
 tb/tb_deal_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/deal_controller.sv
// deal_controller: deals 24-game puzzles. Samples a pseudo-random ROM
// index, rejects indices seen in the last HIST_DEPTH deals (with a bounded
// number of retries), drives the valid-set ROM, latches the four numbers and
// pulses deal_valid to the game FSM. A restart request replays the
// current puzzle without re-dealing.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req_new             1-cycle pulse: deal a fresh puzzle
//   req_restart         1-cycle pulse: replay the current puzzle
//   rand_index          free-running random index (sampled only in SAMPLE)
//   set_num1..4         ROM outputs for rom_index
//   rom_index           index to the valid-set ROM (held in IDLE)
//   num1..4             latched puzzle numbers
//   deal_valid          1-cycle pulse: num1..4 ready (new deal or replay)
//   busy                high in every state but IDLE
//   forced_repeat       last deal took a history match after retries ran out
//   deal_count          completed new deals, wraps

// One history slot comparator; an invalid slot never hits.
module deal_hist_slot #(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] cand,
  input  logic [IDX_W-1:0] slot_idx,
  input  logic             slot_vld,
  output logic             hit
);
  assign hit = slot_vld && (slot_idx == cand);
endmodule

module deal_controller #(
  parameter int IDX_W      = 4,
  parameter int NUM_W      = 10,
  parameter int HIST_DEPTH = 4,
  parameter int MAX_RETRY  = 8,
  parameter int ROM_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_new,
  input  logic             req_restart,
  input  logic [IDX_W-1:0] rand_index,
  input  logic [NUM_W-1:0] set_num1,
  input  logic [NUM_W-1:0] set_num2,
  input  logic [NUM_W-1:0] set_num3,
  input  logic [NUM_W-1:0] set_num4,
  output logic [IDX_W-1:0] rom_index,
  output logic [NUM_W-1:0] num1,
  output logic [NUM_W-1:0] num2,
  output logic [NUM_W-1:0] num3,
  output logic [NUM_W-1:0] num4,
  output logic             deal_valid,
  output logic             busy,
  output logic             forced_repeat,
  output logic [7:0]       deal_count
);

  // lat_cnt runs 0..ROM_LAT-1 while in LOOKUP
  localparam int LAT_W = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT);

  typedef enum logic [2:0] {
    IDLE, SAMPLE, CHECK, LOOKUP, LATCH, DONE, REPLAY
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]                  cand;
  logic [3:0]                        retry_cnt;
  logic [LAT_W-1:0]                  lat_cnt;
  logic                              have_deal;
  logic [HIST_DEPTH-1:0][IDX_W-1:0]  hist_idx;
  logic [HIST_DEPTH-1:0]             hist_vld;
  logic [HIST_DEPTH-1:0]             hit;
  logic                              match;
  logic                              resample;
  logic                              lat_done;

  for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist
    deal_hist_slot #(.IDX_W(IDX_W)) u_slot (
      .cand     (cand),
      .slot_idx (hist_idx[g]),
      .slot_vld (hist_vld[g]),
      .hit      (hit[g])
    );
  end

  assign match    = |hit;
  // Once retries are exhausted a repeat is accepted rather than stalling.
  assign resample = match && (retry_cnt < 4'(MAX_RETRY));
  assign lat_done = (lat_cnt == LAT_W'(ROM_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Requests are only looked at in IDLE, so anything arriving while busy
  // is dropped. req_new has priority over req_restart.
  always_comb begin
    state_nxt  = state;
    deal_valid = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (req_new)                       state_nxt = SAMPLE;
        else if (req_restart && have_deal) state_nxt = REPLAY;
      end
      SAMPLE: state_nxt = CHECK;
      CHECK:  state_nxt = resample ? SAMPLE : LOOKUP;
      LOOKUP: if (lat_done) state_nxt = LATCH;
      LATCH:  state_nxt = DONE;
      DONE: begin
        deal_valid = 1'b1;
        state_nxt  = IDLE;
      end
      REPLAY: begin
        deal_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand          <= '0;
      retry_cnt     <= '0;
      lat_cnt       <= '0;
      have_deal     <= 1'b0;
      rom_index     <= '0;
      forced_repeat <= 1'b0;
      num1          <= '0;
      num2          <= '0;
      num3          <= '0;
      num4          <= '0;
      deal_count    <= '0;
      hist_idx      <= '0;
      hist_vld      <= '0;
    end else begin
      unique case (state)
        IDLE:   if (req_new) retry_cnt <= '0;
        SAMPLE: cand <= rand_index;
        CHECK: begin
          if (resample) begin
            retry_cnt <= retry_cnt + 4'd1;
          end else begin
            rom_index     <= cand;
            forced_repeat <= match;
            lat_cnt       <= '0;
          end
        end
        LOOKUP: lat_cnt <= lat_cnt + LAT_W'(1);
        LATCH: begin
          num1 <= set_num1;
          num2 <= set_num2;
          num3 <= set_num3;
          num4 <= set_num4;
          // slot 0 is newest; the oldest entry falls off the end
          for (int i = HIST_DEPTH - 1; i > 0; i--) begin
            hist_idx[i] <= hist_idx[i-1];
            hist_vld[i] <= hist_vld[i-1];
          end
          hist_idx[0] <= cand;
          hist_vld[0] <= 1'b1;
          deal_count  <= deal_count + 8'd1;
          have_deal   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deal_controller.sv
// Scoreboard bench for deal_controller: stimulus tasks push the expected
// deal (cycle, index, numbers, count, forced flag) into a queue; a monitor
// on the falling edge pops and compares on every deal_valid.
module tb_deal_controller;

  logic        clk;
  logic        rst;
  logic        req_new;
  logic        req_restart;
  logic [3:0]  rand_index;
  logic [9:0]  set_num1, set_num2, set_num3, set_num4;
  logic [3:0]  rom_index;
  logic [9:0]  num1, num2, num3, num4;
  logic        deal_valid;
  logic        busy;
  logic        forced_repeat;
  logic [7:0]  deal_count;

  deal_controller #(
    .IDX_W(4), .NUM_W(10), .HIST_DEPTH(4), .MAX_RETRY(8), .ROM_LAT(1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_new       (req_new),
    .req_restart   (req_restart),
    .rand_index    (rand_index),
    .set_num1      (set_num1),
    .set_num2      (set_num2),
    .set_num3      (set_num3),
    .set_num4      (set_num4),
    .rom_index     (rom_index),
    .num1          (num1),
    .num2          (num2),
    .num3          (num3),
    .num4          (num4),
    .deal_valid    (deal_valid),
    .busy          (busy),
    .forced_repeat (forced_repeat),
    .deal_count    (deal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: hand-written puzzle table.
  function automatic logic [39:0] rom_word(input logic [3:0] i);
    case (i)
      4'd5:    rom_word = {10'd1, 10'd3, 10'd4, 10'd6};
      4'd9:    rom_word = {10'd2, 10'd2, 10'd10, 10'd10};
      4'd7:    rom_word = {10'd3, 10'd3, 10'd8, 10'd8};
      default: rom_word = {10'(i), 10'(i) + 10'd1, 10'(i) + 10'd2, 10'd24};
    endcase
  endfunction

  // ROM with one register stage, so data only settles a cycle after rom_index.
  logic [39:0] rom_q;
  always @(posedge clk) rom_q <= rom_word(rom_index);
  assign {set_num1, set_num2, set_num3, set_num4} = rom_q;

  typedef struct {
    int         cyc;
    logic [3:0] idx;
    logic [39:0] nums;
    logic [7:0] cnt;
    logic       fr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && deal_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_deal_valid: got deal_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("valid_cycle",   cyc, e.cyc);
        chk("rom_index",     rom_index, e.idx);
        chk("nums",          {num1, num2, num3, num4}, e.nums);
        chk("deal_count",    deal_count, e.cnt);
        chk("forced_repeat", forced_repeat, e.fr);
        chk("busy_on_valid", busy, 1);
      end
    end
  end

  // New deal: r0 drives the first sample, r1 every later one. Optionally
  // pulses both requests (simultaneous with req_new, or while busy).
  task automatic deal(input logic [3:0] r0, input logic [3:0] r1, input int lat,
                      input logic [3:0] eidx, input logic efr,
                      input logic both, input int pulse_at);
    exp_t e;
    @(posedge clk); #1;
    model_cnt = model_cnt + 1;
    e.cyc  = cyc + lat;
    e.idx  = eidx;
    e.nums = rom_word(eidx);
    e.cnt  = 8'(model_cnt);
    e.fr   = efr;
    sb.push_back(e);
    rand_index  = r0;
    req_new     = 1'b1;
    req_restart = both;
    @(posedge clk); #1;
    req_new = 1'b0; req_restart = 1'b0;
    @(posedge clk); #1;
    rand_index = r1;
    for (int c = 3; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      req_new     = (c == pulse_at);
      req_restart = (c == pulse_at);
    end
    req_new = 1'b0; req_restart = 1'b0;
  endtask

  task automatic restart(input logic [3:0] eidx, input logic efr);
    exp_t e;
    @(posedge clk); #1;
    e.cyc  = cyc + 1;
    e.idx  = eidx;
    e.nums = rom_word(eidx);
    e.cnt  = 8'(model_cnt);
    e.fr   = efr;
    sb.push_back(e);
    req_restart = 1'b1;
    @(posedge clk); #1;
    req_restart = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_new = 1'b0; req_restart = 1'b0; rand_index = 4'd0;
    #1;
    chk("reset_busy",       busy, 0);
    chk("reset_deal_valid", deal_valid, 0);
    chk("reset_rom_index",  rom_index, 0);
    chk("reset_nums",       {num1, num2, num3, num4}, 0);
    chk("reset_count",      deal_count, 0);
    chk("reset_forced",     forced_repeat, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // restart with no deal yet: ignored
    @(posedge clk); #1 req_restart = 1'b1;
    @(posedge clk); #1 req_restart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("restart_no_deal_busy", busy, 0);
      @(posedge clk); #1;
    end

    // first deal, index 5
    deal(4'd5, 4'd5, 5, 4'd5, 1'b0, 1'b0, 0);
    chk("t1_num1", num1, 10'd1);
    chk("t1_num2", num2, 10'd3);
    chk("t1_num3", num3, 10'd4);
    chk("t1_num4", num4, 10'd6);
    chk("t1_count", deal_count, 8'd1);

    // replay: numbers and count unchanged
    restart(4'd5, 1'b0);

    // 5 in history -> one resample, accepts 9
    deal(4'd5, 4'd9, 7, 4'd9, 1'b0, 1'b0, 0);
    deal(4'd1, 4'd1, 5, 4'd1, 1'b0, 1'b0, 0);
    deal(4'd2, 4'd2, 5, 4'd2, 1'b0, 1'b0, 0);
    deal(4'd3, 4'd3, 5, 4'd3, 1'b0, 1'b0, 0);
    deal(4'd4, 4'd4, 5, 4'd4, 1'b0, 1'b0, 0);
    deal(4'd6, 4'd6, 5, 4'd6, 1'b0, 1'b0, 0);
    // 5 evicted -> accepted directly
    deal(4'd5, 4'd5, 5, 4'd5, 1'b0, 1'b0, 0);

    // 5 held: retries exhausted, repeat forced
    deal(4'd5, 4'd5, 21, 4'd5, 1'b1, 1'b0, 0);
    restart(4'd5, 1'b1);

    // simultaneous req_new + req_restart -> new deal
    deal(4'd7, 4'd7, 5, 4'd7, 1'b0, 1'b1, 0);
    // both requests pulsed while busy -> dropped
    deal(4'd8, 4'd8, 5, 4'd8, 1'b0, 1'b0, 3);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_requests_dropped", busy, 0);

    // reset during LOOKUP
    @(posedge clk); #1;
    rand_index = 4'd10; req_new = 1'b1;
    @(posedge clk); #1 req_new = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy",      busy, 1);
    chk("pre_reset_rom_index", rom_index, 4'd10);
    rst = 1'b1;
    #1;
    chk("midrst_busy",      busy, 0);
    chk("midrst_rom_index", rom_index, 0);
    chk("midrst_nums",      {num1, num2, num3, num4}, 0);
    chk("midrst_count",     deal_count, 0);
    chk("midrst_forced",    forced_repeat, 0);
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // history cleared: 5 taken with no resample
    deal(4'd5, 4'd9, 5, 4'd5, 1'b0, 1'b0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
